reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of write data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter NUM_REGS, default 32, number of architectural registers (2**ADDR_WIDTH).
REQ-004 SHALL have port i_clk  input  1  clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_stall  input  1  when high, blocks new grants.
REQ-007 SHALL have ports i_valid_0 / i_valid_1  input  1 each  write request from requester 0 (ALU writeback) / 1 (load unit).
REQ-008 SHALL have ports i_addr_0 / i_addr_1  input  ADDR_WIDTH each  destination register.
REQ-009 SHALL have ports i_data_0 / i_data_1  input  DATA_WIDTH each  write data.
REQ-010 SHALL have ports o_ready_0 / o_ready_1  output  1 each  grant; handshake when valid and ready are both high on the same edge.
REQ-011 SHALL have port o_reg_write  output  1  register file write enable.
REQ-012 SHALL have port o_write_reg  output  ADDR_WIDTH  register file write address.
REQ-013 SHALL have port o_write_data  output  DATA_WIDTH  register file write data.
REQ-014 SHALL have port o_busy_mask  output  NUM_REGS  bit r high while a committed write to register r is in the output stage.
REQ-015 SHALL have port o_conflict_cnt  output  16  saturating count of contention cycles.

Function
REQ-016 o_ready_n SHALL be combinational from i_valid_*, i_stall and the priority pointer only, never from o_ready_* of the other requester.
REQ-017 At most one o_ready_* SHALL be high per cycle; none while i_stall=1.
REQ-018 Only one requester valid and no stall: that requester SHALL be granted the same cycle.
REQ-019 Both valid and no stall: the requester named by the priority pointer SHALL be granted.
REQ-020 After each handshake, the pointer SHALL move to the other requester; with no handshake, the pointer SHALL hold.
REQ-021 A handshake at edge t SHALL present the address and data on o_write_reg/o_write_data during cycle t+1 (latency 1), with o_reg_write high for exactly that cycle unless another handshake follows.
REQ-022 Back-to-back handshakes SHALL produce o_reg_write high on consecutive cycles, with no bubble.
REQ-023 A request to address 0 SHALL be accepted normally (consumes the slot, moves the pointer); o_reg_write SHALL stay 0 for it, and o_busy_mask bit 0 SHALL never be set.
REQ-024 Same address from both requesters in one cycle: writes SHALL commit in grant order, so the loser's data is the final register value.
REQ-025 o_busy_mask SHALL be the one-hot decode of o_write_reg when o_reg_write=1, else all zero.
REQ-026 o_conflict_cnt SHALL increment when both valid, not stalled and one is denied; it SHALL saturate at 16'hFFFF.
REQ-027 A requester SHALL hold valid, addr and data stable until its handshake; the arbiter is not required to handle withdrawal.
REQ-028 With no handshake in cycle t, o_reg_write SHALL be 0 in cycle t+1; o_write_reg/o_write_data SHALL hold their last values.

Reset
REQ-029 While i_rst_n=0: o_reg_write=0, o_write_reg=0, o_write_data=0, o_busy_mask=0, o_conflict_cnt=0, pointer=requester 0.
REQ-030 o_ready_* SHALL be 0 while i_rst_n=0.
REQ-031 Reset asserted mid-operation SHALL drop any write in the output stage (no commit); requesters SHALL re-present after release.
REQ-032 The first grant is permitted on the first rising edge after i_rst_n deasserts.

Structure
REQ-033 Package regfile_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, NUM_REGS, the requester id enum (REQ_ALU=0, REQ_LOAD=1) and the struct wr_req_t {addr, data}.
REQ-034 Sub-module rr_arbiter_2 SHALL implement the two-way round-robin grant and pointer; reg_write_arbiter SHALL hold the output stage, busy mask and counter.

Verification
REQ-035 Only req0 valid with addr 5, data 64'hDEAD: o_ready_0=1 the same cycle; next cycle o_reg_write=1, o_write_reg=5, o_busy_mask=32'h20.
REQ-036 Both valid for 4 cycles after reset: grants alternate 0,1,0,1; o_conflict_cnt increments per denied cycle; outputs are continuous with no bubble.
REQ-037 Both valid with addr 7: req0 data=1, req1 data=2: two consecutive writes; the register file reads 2 at reg 7.
REQ-038 req1 valid with addr 0: o_ready_1=1; next cycle o_reg_write=0 and o_busy_mask=0; the pointer moves to 0.
REQ-039 i_stall=1 with both valid for 3 cycles: no grants, o_reg_write=0, o_conflict_cnt unchanged.
REQ-040 Reset pulsed the cycle after a handshake: no register write occurs, all outputs are 0, and the pointer returns to 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file write path.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant; the pointer names the winner when both requesters are valid.
module rr_arbiter_2
  import regfile_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic stall,
  input  logic valid_0,
  input  logic valid_1,
  output logic ready_0,
  output logic ready_1,
  output logic contend
);

  req_id_e ptr_q, ptr_d;

  // A grant implies valid, so ready alone marks the handshake.
  always_comb begin
    ready_0 = i_rst_n & ~stall & valid_0 & (~valid_1 | (ptr_q == REQ_ALU));
    ready_1 = i_rst_n & ~stall & valid_1 & (~valid_0 | (ptr_q == REQ_LOAD));
    contend = i_rst_n & ~stall & valid_0 & valid_1;
    ptr_d   = ptr_q;
    if (ready_0) begin
      ptr_d = REQ_LOAD;
    end else if (ready_1) begin
      ptr_d = REQ_ALU;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= REQ_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port with a one-cycle stage.
module reg_write_arbiter #(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = regfile_pkg::NUM_REGS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic                  i_valid_0,
  input  logic [ADDR_WIDTH-1:0] i_addr_0,
  input  logic [DATA_WIDTH-1:0] i_data_0,
  input  logic                  i_valid_1,
  input  logic [ADDR_WIDTH-1:0] i_addr_1,
  input  logic [DATA_WIDTH-1:0] i_data_1,
  output logic                  o_ready_0,
  output logic                  o_ready_1,
  output logic                  o_reg_write,
  output logic [ADDR_WIDTH-1:0] o_write_reg,
  output logic [DATA_WIDTH-1:0] o_write_data,
  output logic [NUM_REGS-1:0]   o_busy_mask,
  output logic [15:0]           o_conflict_cnt
);

  logic                  gnt_0, gnt_1, contend, hs;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [15:0]           cnt_q;

  rr_arbiter_2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .stall   (i_stall),
    .valid_0 (i_valid_0),
    .valid_1 (i_valid_1),
    .ready_0 (gnt_0),
    .ready_1 (gnt_1),
    .contend (contend)
  );

  // Writes to register 0 still take the slot but never raise the write enable.
  always_comb begin
    hs       = gnt_0 | gnt_1;
    sel_addr = gnt_1 ? i_addr_1 : i_addr_0;
    sel_data = gnt_1 ? i_data_1 : i_data_0;
    wr_d     = hs & (sel_addr != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      wr_q <= wr_d;
      if (hs) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
      if (contend && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    o_busy_mask = '0;
    if (wr_q) begin
      o_busy_mask[addr_q] = 1'b1;
    end
  end

  assign o_ready_0      = gnt_0;
  assign o_ready_1      = gnt_1;
  assign o_reg_write    = wr_q;
  assign o_write_reg    = addr_q;
  assign o_write_data   = data_q;
  assign o_conflict_cnt = cnt_q;

endmodule
